// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    SQUASH,
    MEMWAIT
  } hz_state_t;

  localparam int unsigned REG_ZERO = 0;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;
  localparam int unsigned SQ_W     = $clog2(16);

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at its maximum instead of wrapping.
module sat_counter16
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, redirect squash and memory-freeze sequencing for the 5-stage pipeline.
// Control outputs are Mealy; state, squash count and perf counters are registered.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned SQUASH_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      redir_cnt
);

  localparam logic [SQ_W-1:0] SqReload = SQ_W'(SQUASH_CYC - 1);

  hz_state_t       state_q, state_d;
  hz_state_t       ret_q, ret_d;
  hz_state_t       eff_state;
  logic [SQ_W-1:0] sq_left_q, sq_left_d;

  logic redirect, load_use, redir_acc;
  logic c_pc_hold, c_ifid_hold, c_ifid_flush, c_idex_hold, c_idex_flush, c_exmem_hold;

  assign redirect = ex_branch_taken | ex_jump;
  assign load_use = ex_memread && (ex_rt != REG_W'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Leaving MEMWAIT resumes the saved state within the same cycle.
  assign eff_state = (state_q == MEMWAIT) ? ret_q : state_q;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    sq_left_d    = sq_left_q;
    redir_acc    = 1'b0;
    c_pc_hold    = 1'b0;
    c_ifid_hold  = 1'b0;
    c_ifid_flush = 1'b0;
    c_idex_hold  = 1'b0;
    c_idex_flush = 1'b0;
    c_exmem_hold = 1'b0;

    if (mem_busy) begin
      c_pc_hold    = 1'b1;
      c_ifid_hold  = 1'b1;
      c_idex_hold  = 1'b1;
      c_exmem_hold = 1'b1;
      state_d      = MEMWAIT;
      ret_d        = eff_state;
    end else begin
      state_d = eff_state;
      unique case (eff_state)
        SQUASH: begin
          c_ifid_flush = 1'b1;
          if (redirect) begin
            c_idex_flush = 1'b1;
            redir_acc    = 1'b1;
            sq_left_d    = SqReload;
          end else if (sq_left_q <= SQ_W'(1)) begin
            state_d   = RUN;
            sq_left_d = '0;
          end else begin
            sq_left_d = sq_left_q - SQ_W'(1);
          end
        end
        default: begin
          if (redirect) begin
            c_ifid_flush = 1'b1;
            c_idex_flush = 1'b1;
            redir_acc    = 1'b1;
            if (SQUASH_CYC > 1) begin
              state_d   = SQUASH;
              sq_left_d = SqReload;
            end
          end else if (load_use) begin
            c_pc_hold    = 1'b1;
            c_ifid_hold  = 1'b1;
            c_idex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      ret_q     <= RUN;
      sq_left_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      sq_left_q <= sq_left_d;
    end
  end

  assign pc_hold    = rst & c_pc_hold;
  assign ifid_hold  = rst & c_ifid_hold;
  assign ifid_flush = rst & c_ifid_flush;
  assign idex_hold  = rst & c_idex_hold;
  assign idex_flush = rst & c_idex_flush;
  assign exmem_hold = rst & c_exmem_hold;

  sat_counter16 u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_hold),
    .cnt (stall_cnt)
  );

  sat_counter16 u_redir_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rst & redir_acc),
    .cnt (redir_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with a three-cycle squash window.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RegW = 5;

  // Expected control vector: {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold}
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] LU    = 6'b110010;
  localparam logic [5:0] MEM   = 6'b110101;
  localparam logic [5:0] REDIR = 6'b001010;
  localparam logic [5:0] SQ    = 6'b001000;

  typedef struct {
    string       tag;
    logic [5:0]  ctrl;
    logic [15:0] stall;
    logic [15:0] redir;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [RegW-1:0] id_rs, id_rt, ex_rt;
  logic            id_uses_rt, ex_memread, ex_branch_taken, ex_jump, mem_busy;
  logic            pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold;
  logic [15:0]     stall_cnt, redir_cnt;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] exp_stall = '0;
  logic [15:0] exp_redir = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_W      (RegW),
    .SQUASH_CYC (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_jump         (ex_jump),
    .mem_busy        (mem_busy),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .ifid_flush      (ifid_flush),
    .idex_hold       (idex_hold),
    .idex_flush      (idex_flush),
    .exmem_hold      (exmem_hold),
    .stall_cnt       (stall_cnt),
    .redir_cnt       (redir_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  task automatic drive(input logic r, input logic busy, input logic br, input logic jmp,
                       input logic mrd, input logic [RegW-1:0] ert, input logic [RegW-1:0] rs,
                       input logic [RegW-1:0] rt, input logic uses);
    rst = r; mem_busy = busy; ex_branch_taken = br; ex_jump = jmp;
    ex_memread = mrd; ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = uses;
  endtask

  // One checked cycle: push the expectation when driving, pop and compare when sampling.
  task automatic step(input string tag, input logic r, input logic busy, input logic br,
                      input logic jmp, input logic mrd, input logic [RegW-1:0] ert,
                      input logic [RegW-1:0] rs, input logic [RegW-1:0] rt, input logic uses,
                      input logic [5:0] exp_ctrl);
    exp_t e, got;
    @(negedge clk);
    drive(r, busy, br, jmp, mrd, ert, rs, rt, uses);
    e.tag = tag; e.ctrl = exp_ctrl; e.stall = exp_stall; e.redir = exp_redir;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    check({got.tag, ".ctrl"}, 32'({pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
                                   exmem_hold}), 32'(got.ctrl));
    check({got.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(got.stall));
    check({got.tag, ".redir_cnt"}, 32'(redir_cnt), 32'(got.redir));
    if (!r) begin
      exp_stall = '0;
      exp_redir = '0;
    end else begin
      exp_stall = sat_inc(exp_stall, exp_ctrl[5]);
      exp_redir = sat_inc(exp_redir, exp_ctrl[3] & exp_ctrl[1]);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);

    //    tag          rst  busy br   jmp  mrd  ert    rs     rt     uses  expected
    step("rst_force",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, NONE);
    step("idle",       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, NONE);
    step("lu_rs",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd2, 1'b0, LU);
    step("lu_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd2, 1'b0, NONE);
    step("lu_r0",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, NONE);
    step("lu_rt",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, LU);
    step("lu_rt_nouse",1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, NONE);
    step("br",         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, REDIR);
    step("sq1",        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, SQ);
    step("sq2_nolu",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, SQ);
    step("sq_done",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, NONE);
    step("jmp_and_lu", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, REDIR);
    step("sq_a",       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, SQ);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("memwait%0d", i),
                       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MEM);
    end
    step("sq_resume",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, SQ);
    step("sq_resumed", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, NONE);
    step("br_frozen",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MEM);
    step("br_after",   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, REDIR);
    step("sq_reload",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, REDIR);
    step("sq_r1",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, SQ);
    step("sq_r2",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, SQ);
    step("sq_r_done",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, NONE);
    step("br_pre_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, REDIR);
    step("rst_mid_sq", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, NONE);
    step("no_residual",1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, NONE);

    // Bulk freeze to bring stall_cnt up to 0xFFFD without per-cycle checks.
    begin
      int unsigned n;
      n = 32'hFFFD;
      for (int unsigned i = 0; i < n; i++) begin
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        exp_stall = sat_inc(exp_stall, 1'b1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step($sformatf("sat%0d", i),
                       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MEM);
    end
    step("rst_mid_mw", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, NONE);
    step("post_rst",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
